// File: rtl/duck_pkg.sv
// Shared types and sprite geometry for the duck sprite fetch path.
package duck_pkg;

  typedef enum logic [1:0] {
    FLYING  = 2'd0,
    HIT     = 2'd1,
    FALLING = 2'd2,
    GONE    = 2'd3
  } duck_state_t;

  localparam int unsigned DUCK_SPR_W      = 38;
  localparam int unsigned DUCK_SPR_H      = 38;
  localparam int unsigned DUCK_NUM_FRAMES = 6;
  localparam int unsigned FRAME_W         = $clog2(DUCK_NUM_FRAMES);

endpackage

// File: rtl/duck_anim_fsm.sv
// Duck life-cycle state machine plus vsync-paced animation counters and frame select.
module duck_anim_fsm
  import duck_pkg::*;
#(
  parameter int unsigned ANIM_DIV = 8,
  parameter int unsigned HIT_HOLD = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync,
  input  logic               shot,
  input  logic               fall_done,
  input  logic               respawn,
  output logic [1:0]         state,
  output logic [FRAME_W-1:0] frame
);

  localparam int unsigned ANIM_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int unsigned HOLD_W = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;

  duck_state_t        state_q, state_d;
  logic               vs_q;
  logic               vs_fall;
  logic [ANIM_W-1:0]  anim_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               anim_wrap;
  logic               hold_last;
  logic               enter_hit;
  logic               dir_down, dir_d;
  logic [FRAME_W-1:0] frame_d;

  // vsync is active-low: its falling edge opens a new frame
  assign vs_fall   = vs_q & ~vsync;
  assign anim_wrap = (anim_cnt == ANIM_W'(ANIM_DIV - 1));
  assign hold_last = (hold_cnt == HOLD_W'(HIT_HOLD - 1));
  assign enter_hit = (state_q == FLYING) && (state_d == HIT);
  assign state     = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FLYING;
      vs_q     <= 1'b0;
      anim_cnt <= '0;
      hold_cnt <= '0;
      frame    <= '0;
      dir_down <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_q    <= vsync;
      if (enter_hit)    anim_cnt <= '0;
      else if (vs_fall) anim_cnt <= anim_wrap ? '0 : anim_cnt + ANIM_W'(1);
      if (enter_hit)
        hold_cnt <= '0;
      else if (vs_fall && (state_q == HIT) && !hold_last)
        hold_cnt <= hold_cnt + HOLD_W'(1);
      if (vs_fall) begin
        frame    <= frame_d;
        dir_down <= dir_d;
      end
    end
  end

  // Next state and next frame; frame only commits on vs_fall so a scan frame never tears
  always_comb begin
    state_d = state_q;
    frame_d = frame;
    dir_d   = dir_down;
    if (respawn) begin
      state_d = FLYING;
    end else begin
      unique case (state_q)
        FLYING:  if (shot) state_d = HIT;
        HIT:     if (vs_fall && hold_last) state_d = FALLING;
        FALLING: if (fall_done) state_d = GONE;
        GONE:    state_d = GONE;
        default: state_d = FLYING;
      endcase
    end

    unique case (state_q)
      FLYING: begin
        if (frame > FRAME_W'(2)) begin
          frame_d = '0;
          dir_d   = 1'b0;
        end else if (anim_wrap) begin
          if (frame == FRAME_W'(0)) begin
            frame_d = FRAME_W'(1);
            dir_d   = 1'b0;
          end else if (frame == FRAME_W'(2)) begin
            frame_d = FRAME_W'(1);
            dir_d   = 1'b1;
          end else begin
            frame_d = dir_down ? FRAME_W'(0) : FRAME_W'(2);
          end
        end
      end
      HIT: frame_d = FRAME_W'(3);
      FALLING: begin
        if ((frame != FRAME_W'(4)) && (frame != FRAME_W'(5)))
          frame_d = FRAME_W'(4);
        else if (anim_wrap)
          frame_d = (frame == FRAME_W'(4)) ? FRAME_W'(5) : FRAME_W'(4);
      end
      default: frame_d = frame;
    endcase
  end

endmodule

// File: rtl/duck_sprite_fetch.sv
// Turns scan position and duck position into a sprite-ROM address and a masked palette index.
module duck_sprite_fetch
  import duck_pkg::*;
#(
  parameter int unsigned SPR_W    = DUCK_SPR_W,
  parameter int unsigned SPR_H    = DUCK_SPR_H,
  parameter int unsigned ANIM_DIV = 8,
  parameter int unsigned HIT_HOLD = 30,
  parameter int unsigned ADDR_W   = 14
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              vsync,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic [9:0]        duck_x,
  input  logic [9:0]        duck_y,
  input  logic              facing_left,
  input  logic              shot,
  input  logic              fall_done,
  input  logic              respawn,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        pix_index,
  output logic              duck_on,
  output logic [1:0]        duck_state
);

  localparam int unsigned FRAME_SZ = SPR_W * SPR_H;

  logic [1:0]         state;
  logic [FRAME_W-1:0] frame;
  logic [9:0]         dx, dy, col;
  logic               in_box;
  logic               in_box_d1, in_box_d2;
  logic [ADDR_W-1:0]  addr_c;

  duck_anim_fsm #(
    .ANIM_DIV (ANIM_DIV),
    .HIT_HOLD (HIT_HOLD)
  ) u_anim (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .vsync     (vsync),
    .shot      (shot),
    .fall_done (fall_done),
    .respawn   (respawn),
    .state     (state),
    .frame     (frame)
  );

  // Unsigned wrap makes positions left of / above the sprite compare as huge
  assign dx     = draw_x - duck_x;
  assign dy     = draw_y - duck_y;
  assign in_box = (dx < 10'(SPR_W)) && (dy < 10'(SPR_H)) && (state != GONE);
  assign col    = facing_left ? (10'(SPR_W - 1) - dx) : dx;
  assign addr_c = ADDR_W'(frame) * ADDR_W'(FRAME_SZ)
                + ADDR_W'(dy) * ADDR_W'(SPR_W)
                + ADDR_W'(col);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr  <= '0;
      in_box_d1 <= 1'b0;
      in_box_d2 <= 1'b0;
    end else begin
      if (in_box) rom_addr <= addr_c;
      in_box_d1 <= in_box;
      in_box_d2 <= in_box_d1;
    end
  end

  // ROM output is already registered, so the final mask is applied combinationally
  assign pix_index  = in_box_d2 ? rom_data : 4'd0;
  assign duck_on    = in_box_d2 && (rom_data != 4'd0);
  assign duck_state = state;

endmodule

// File: tb/tb_duck_sprite_fetch.sv
// Scoreboard bench for duck_sprite_fetch with a 1-clock synchronous sprite ROM model.
module tb_duck_sprite_fetch;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        vsync;
  logic [9:0]  draw_x, draw_y, duck_x, duck_y;
  logic        facing_left, shot, fall_done, respawn;
  logic [13:0] rom_addr;
  logic [3:0]  rom_data = 4'd0;
  logic [3:0]  pix_index;
  logic        duck_on;
  logic [1:0]  duck_state;

  typedef struct {
    int          due;
    int          kind;   // 0 addr, 1 pix, 2 on, 3 state
    logic [13:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t keep[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_bad  = 0;

  duck_sprite_fetch dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .vsync       (vsync),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .duck_x      (duck_x),
    .duck_y      (duck_y),
    .facing_left (facing_left),
    .shot        (shot),
    .fall_done   (fall_done),
    .respawn     (respawn),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pix_index   (pix_index),
    .duck_on     (duck_on),
    .duck_state  (duck_state)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // ROM contents: nonzero everywhere except address 1443 (a transparent pixel)
  function automatic logic [3:0] rom_f(input logic [13:0] a);
    logic [13:0] m;
    if (a == 14'd1443) return 4'd0;
    m = a % 14'd15;
    return m[3:0] + 4'd1;
  endfunction

  always @(posedge Clk) rom_data <= rom_f(rom_addr);

  task automatic check(input string nm, input logic [13:0] act, input logic [13:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void push(input int due, input int kind, input logic [13:0] v, input string nm);
    exp_t e;
    e.due  = due;
    e.kind = kind;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endfunction

  // Monitor: compare every expectation that falls due this cycle
  always @(negedge Clk) begin
    keep.delete();
    foreach (sb[i]) begin
      if (sb[i].due <= cyc) begin
        case (sb[i].kind)
          0:       check(sb[i].name, rom_addr, sb[i].val);
          1:       check(sb[i].name, 14'(pix_index), sb[i].val);
          2:       check(sb[i].name, 14'(duck_on), sb[i].val);
          default: check(sb[i].name, 14'(duck_state), sb[i].val);
        endcase
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  task automatic park();
    draw_x = 10'd0; draw_y = 10'd0; duck_x = 10'd100; duck_y = 10'd50;
    facing_left = 1'b0; shot = 1'b0; fall_done = 1'b0; respawn = 1'b0; vsync = 1'b1;
  endtask

  task automatic pixel(input logic [9:0] dxp, input logic [9:0] dyp, input logic [9:0] uxp,
                       input logic [9:0] uyp, input logic fl, input logic [13:0] ea,
                       input logic eib, input string nm);
    logic [3:0] ep;
    @(posedge Clk); #1;
    park();
    draw_x = dxp; draw_y = dyp; duck_x = uxp; duck_y = uyp; facing_left = fl;
    ep = eib ? rom_f(ea) : 4'd0;
    push(cyc + 1, 0, ea, {nm, "_addr"});
    push(cyc + 2, 1, 14'(ep), {nm, "_pix"});
    push(cyc + 2, 2, 14'(ep != 4'd0), {nm, "_on"});
  endtask

  task automatic ctrl(input logic s, input logic f, input logic r, input logic [1:0] est,
                      input string nm);
    @(posedge Clk); #1;
    park();
    shot = s; fall_done = f; respawn = r;
    push(cyc + 1, 3, 14'(est), nm);
  endtask

  task automatic vs_pulse(input logic chk, input logic [1:0] est, input string nm);
    @(posedge Clk); #1;
    park();
    vsync = 1'b0;
    if (chk) push(cyc + 1, 3, 14'(est), nm);
    @(posedge Clk); #1;
    vsync = 1'b1;
  endtask

  task automatic drain();
    @(posedge Clk); #1;
    shot = 1'b0; fall_done = 1'b0; respawn = 1'b0; vsync = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge Clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fseq[4];
    int fr;
    fseq = '{0, 1, 2, 1};
    Reset_n = 1'b0;
    park();

    #3;
    check("rst_addr",  rom_addr, 14'd0);
    check("rst_pix",   14'(pix_index), 14'd0);
    check("rst_on",    14'(duck_on), 14'd0);
    check("rst_state", 14'(duck_state), 14'd0);
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;

    // Basic addressing, box edges, transparency
    pixel(10'd100, 10'd50, 10'd100, 10'd50, 1'b0, 14'd0,    1'b1, "t1_origin");
    pixel(10'd137, 10'd87, 10'd100, 10'd50, 1'b0, 14'd1443, 1'b1, "t2_corner");
    pixel(10'd138, 10'd87, 10'd100, 10'd50, 1'b0, 14'd1443, 1'b0, "t2_right_out");
    pixel(10'd99,  10'd50, 10'd100, 10'd50, 1'b0, 14'd1443, 1'b0, "t2_left_out");
    pixel(10'd100, 10'd88, 10'd100, 10'd50, 1'b0, 14'd1443, 1'b0, "t2_below_out");
    pixel(10'd120, 10'd60, 10'd100, 10'd50, 1'b0, 14'd400,  1'b1, "t2_mid");
    // Mirroring and wrap-around rejection
    pixel(10'd100, 10'd50, 10'd100, 10'd50, 1'b1, 14'd37,   1'b1, "t3_mirror");
    pixel(10'd137, 10'd51, 10'd100, 10'd50, 1'b1, 14'd38,   1'b1, "t3_mirror_edge");
    pixel(10'd990, 10'd50, 10'd1000, 10'd50, 1'b0, 14'd38,  1'b0, "t3_wrap_out");
    drain();

    // Flying ping-pong, two pixels per frame to show no mid-frame change
    for (int k = 1; k <= 32; k++) begin
      vs_pulse(1'b0, 2'd0, "");
      fr = fseq[(k / 8) % 4];
      pixel(10'd100, 10'd50, 10'd100, 10'd50, 1'b0, 14'(fr * 1444), 1'b1, $sformatf("t4_k%0d_a", k));
      pixel(10'd100, 10'd50, 10'd100, 10'd50, 1'b0, 14'(fr * 1444), 1'b1, $sformatf("t4_k%0d_b", k));
    end
    drain();

    // Hit, hold, fall, gone
    ctrl(1'b1, 1'b0, 1'b0, 2'd1, "t5_shot");
    pixel(10'd100, 10'd50, 10'd100, 10'd50, 1'b0, 14'd0, 1'b1, "t5_hit_before_vs");
    vs_pulse(1'b1, 2'd1, "t5_hold_1");
    pixel(10'd100, 10'd50, 10'd100, 10'd50, 1'b0, 14'd4332, 1'b1, "t5_hit_pose");
    for (int k = 2; k <= 29; k++) vs_pulse(1'b1, 2'd1, $sformatf("t5_hold_%0d", k));
    vs_pulse(1'b1, 2'd2, "t5_to_falling");
    vs_pulse(1'b1, 2'd2, "t5_falling_a");
    pixel(10'd100, 10'd50, 10'd100, 10'd50, 1'b0, 14'd5776, 1'b1, "t5_frame4");
    vs_pulse(1'b1, 2'd2, "t5_falling_b");
    pixel(10'd100, 10'd50, 10'd100, 10'd50, 1'b0, 14'd7220, 1'b1, "t5_frame5");
    ctrl(1'b0, 1'b1, 1'b0, 2'd3, "t5_gone");
    pixel(10'd100, 10'd50, 10'd100, 10'd50, 1'b0, 14'd7220, 1'b0, "t5_gone_pix");
    pixel(10'd120, 10'd60, 10'd100, 10'd50, 1'b0, 14'd7220, 1'b0, "t5_gone_mid");
    ctrl(1'b1, 1'b0, 1'b0, 2'd3, "t5_shot_ignored");

    // Respawn beats shot; frame stays until the next vsync
    ctrl(1'b1, 1'b0, 1'b1, 2'd0, "t6_respawn");
    pixel(10'd100, 10'd50, 10'd100, 10'd50, 1'b0, 14'd7220, 1'b1, "t6_respawn_pix");
    ctrl(1'b1, 1'b0, 1'b0, 2'd1, "t6_shot_again");
    drain();

    // Asynchronous reset in the middle of a scan line
    @(posedge Clk); #1;
    park();
    draw_x = 10'd120; draw_y = 10'd60;
    @(posedge Clk); @(posedge Clk); #2;
    Reset_n = 1'b0;
    #1;
    check("t6_async_addr",  rom_addr, 14'd0);
    check("t6_async_pix",   14'(pix_index), 14'd0);
    check("t6_async_on",    14'(duck_on), 14'd0);
    check("t6_async_state", 14'(duck_state), 14'd0);
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    push(cyc,     3, 14'd0,   "t6_rel_state");
    push(cyc,     1, 14'd0,   "t6_rel_p0_pix");
    push(cyc,     2, 14'd0,   "t6_rel_p0_on");
    push(cyc + 1, 1, 14'd0,   "t6_rel_p1_pix");
    push(cyc + 1, 2, 14'd0,   "t6_rel_p1_on");
    push(cyc + 1, 0, 14'd400, "t6_rel_addr");
    push(cyc + 2, 1, 14'd11,  "t6_rel_p2_pix");
    push(cyc + 2, 2, 14'd1,   "t6_rel_p2_on");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
